ecc_scrub_ctrl: RTL and testbench
=================================

// Module: ecc_scrub_ctrl
// PURPOSE
//   Memory scrub sequencer around the combinational c1908 SEC/DED decoder.
//   - Walks a memory: address 0 up to DEPTH-1.
//   - Feeds each stored codeword to the decoder.
//   - Writes the corrected codeword back when a single-bit error is corrected.
//   - Counts corrected and uncorrectable events; logs the first uncorrectable address.
//   - Sits between the scrub scheduler (start_i) and one memory port.
// PARAMETERS
//   ADDR_W  8   memory address width
//   DEPTH   256 words scrubbed per pass, 1..2**ADDR_W
//   DATA_W  16  data bits per codeword
//   CHK_W   6   check bits per codeword; codeword width CW_W = DATA_W+CHK_W
//   CNT_W   8   width of each error counter (saturating)
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous, active-high reset
//   start_i     in   1       pulse: begin one scrub pass (ignored while busy_o=1)
//   busy_o      out  1       pass in progress
//   done_o      out  1       one-cycle pulse when a pass completes
//   mem_req_o   out  1       memory request, held until mem_ack_i
//   mem_we_o    out  1       1=write, 0=read; stable while mem_req_o=1
//   mem_addr_o  out  ADDR_W  memory address
//   mem_wdata_o out  CW_W    write codeword
//   mem_rdata_i in   CW_W    read codeword, valid in the mem_ack_i cycle of a read
//   mem_ack_i   in   1       request accepted; may be high in the first req cycle
//   dec_cw_o    out  CW_W    registered codeword driven to the decoder
//   dec_cw_i    in   CW_W    corrected codeword from the decoder (combinational)
//   dec_sec_i   in   1       decoder: single error corrected
//   dec_ded_i   in   1       decoder: double error detected
//   sec_cnt_o   out  CNT_W   corrected-error count for the current/last pass
//   ded_cnt_o   out  CNT_W   uncorrectable-error count
//   ded_flag_o  out  1       sticky: at least one DED seen this pass
//   ded_addr_o  out  ADDR_W  address of the first DED this pass
// BEHAVIOUR
//   Reset: asynchronous, active-high; every output and register is 0; FSM goes to IDLE.
//     Reset mid-transaction drops mem_req_o at once; no partial write completes.
//   FSM states: IDLE, RD, CHK, WB, NXT.
//     IDLE: busy_o=0. On start_i: addr=0; counters, flag and ded_addr cleared; go to RD.
//     RD: req=1, we=0. On ack: capture mem_rdata_i into cw_q (drives dec_cw_o); go to CHK.
//     CHK (exactly 1 cycle): decoder outputs sampled.
//       - dec_sec_i=1 (takes priority over dec_ded_i): sec_cnt++; latch dec_cw_i into wdata; go to WB.
//       - else dec_ded_i=1: ded_cnt++; if ded_flag_o=0, set it and ded_addr=addr; go to NXT.
//       - else go to NXT.
//     WB: req=1, we=1, wdata = corrected codeword, address unchanged. On ack go to NXT.
//     NXT: if addr==DEPTH-1: done_o=1 this cycle, addr=0, go to IDLE. Else addr++, go to RD.
//   Handshake: addr, we and wdata are stable from req rise to ack. req is low in the
//     cycle after ack (CHK or NXT), so back-to-back requests are never merged.
//   Latency with zero-wait memory: 3 cycles per clean or DED word, 4 per SEC word.
//     A clean pass takes 3*DEPTH busy cycles; done_o is in the last NXT cycle.
//   Counters saturate at 2**CNT_W-1 and never wrap.
//   Counters, flag and ded_addr hold after done until the next start_i.
//   start_i while busy is ignored. start_i in the same cycle as done_o is also ignored
//     (the FSM is not yet in IDLE).
//   DEPTH=1: RD, CHK, NXT, then done.
// TESTING
//   DEPTH=4, zero-wait memory, clean words, start_i -> busy_o high 12 cycles, done_o at cycle 12, counts 0, no writes.
//   Addr 2 has 1 flipped bit; decoder model asserts sec -> write to addr 2 with corrected word, sec_cnt_o=1.
//   DED at addr 1 and addr 3 -> no writes, ded_cnt_o=2, ded_flag_o=1, ded_addr_o=1.
//   mem_ack_i delayed 3 cycles on every request -> req/addr/we/wdata stable throughout; results same as clean case.
//   CNT_W=2, DEPTH=6, all words SEC -> sec_cnt_o=3 (saturated), 6 writebacks.
//   rst pulsed during a WB wait -> all outputs 0 asynchronously; a new start_i rescans from addr 0.

Source files
------------

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: memory scrub sequencer wrapped around an external
// combinational SEC/DED decoder. Walks addresses 0..DEPTH-1 once per start
// pulse. A single-bit error is written back corrected. Corrected and
// uncorrectable events are counted, and the first uncorrectable address is logged.
module ecc_scrub_ctrl #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CHK_W  = 6,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned CW_W   = DATA_W + CHK_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [CW_W-1:0]   mem_wdata_o,
   input  logic [CW_W-1:0]   mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [CW_W-1:0]   dec_cw_o,
   input  logic [CW_W-1:0]   dec_cw_i,
   input  logic              dec_sec_i,
   input  logic              dec_ded_i,
   output logic [CNT_W-1:0]  sec_cnt_o,
   output logic [CNT_W-1:0]  ded_cnt_o,
   output logic              ded_flag_o,
   output logic [ADDR_W-1:0] ded_addr_o
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CHK,
      WB,
      NXT
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t              state;
   logic [ADDR_W-1:0]   addr;
   logic [CW_W-1:0]     cw_q;
   logic [CW_W-1:0]     wdata;
   logic [CNT_W-1:0]    sec_cnt;
   logic [CNT_W-1:0]    ded_cnt;
   logic                ded_flag;
   logic [ADDR_W-1:0]   ded_addr;
   logic                busy;
   logic                done;
   logic                req;
   logic                we;

   // Scrub sequencer. All outputs are registered, so the request, write enable,
   // busy and done signals change only on clock edges. Reset clears them
   // immediately, so a pending request is dropped without completing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         addr     <= '0;
         cw_q     <= '0;
         wdata    <= '0;
         sec_cnt  <= '0;
         ded_cnt  <= '0;
         ded_flag <= 1'b0;
         ded_addr <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         req      <= 1'b0;
         we       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  addr     <= '0;
                  sec_cnt  <= '0;
                  ded_cnt  <= '0;
                  ded_flag <= 1'b0;
                  ded_addr <= '0;
                  busy     <= 1'b1;
                  req      <= 1'b1;
                  we       <= 1'b0;
                  state    <= RD;
               end
            end
            RD: begin
               if (mem_ack_i) begin
                  cw_q  <= mem_rdata_i;
                  req   <= 1'b0;
                  state <= CHK;
               end
            end
            CHK: begin
               // SEC wins over DED when the decoder flags both.
               if (dec_sec_i) begin
                  if (sec_cnt != '1) sec_cnt <= sec_cnt + 1'b1;
                  wdata <= dec_cw_i;
                  req   <= 1'b1;
                  we    <= 1'b1;
                  state <= WB;
               end else begin
                  if (dec_ded_i) begin
                     if (ded_cnt != '1) ded_cnt <= ded_cnt + 1'b1;
                     if (!ded_flag) begin
                        ded_flag <= 1'b1;
                        ded_addr <= addr;
                     end
                  end
                  done  <= (addr == LAST_ADDR);
                  state <= NXT;
               end
            end
            WB: begin
               if (mem_ack_i) begin
                  req   <= 1'b0;
                  we    <= 1'b0;
                  done  <= (addr == LAST_ADDR);
                  state <= NXT;
               end
            end
            NXT: begin
               // done was raised on entry to this state, so it pulses during
               // the final NXT cycle, while busy is still high.
               if (addr == LAST_ADDR) begin
                  addr  <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  addr  <= addr + 1'b1;
                  req   <= 1'b1;
                  we    <= 1'b0;
                  state <= RD;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               req   <= 1'b0;
               we    <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy;
   assign done_o      = done;
   assign mem_req_o   = req;
   assign mem_we_o    = we;
   assign mem_addr_o  = addr;
   assign mem_wdata_o = wdata;
   assign dec_cw_o    = cw_q;
   assign sec_cnt_o   = sec_cnt;
   assign ded_cnt_o   = ded_cnt;
   assign ded_flag_o  = ded_flag;
   assign ded_addr_o  = ded_addr;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Testbench for ecc_scrub_ctrl. It builds two instances: unit 0 uses DEPTH=4
// and CNT_W=8, and unit 1 uses DEPTH=6 and CNT_W=2. Each unit has its own
// memory model and toy decoder. In the decoder, bit 21 marks a correctable
// flip and bit 20 marks an uncorrectable word. Expected writebacks and
// end-of-pass results are queued by the stimulus and consumed by a monitor.
module tb_ecc_scrub_ctrl;

   logic        clk;
   logic        rst;
   logic        start   [2];
   logic        busy    [2];
   logic        done    [2];
   logic        req     [2];
   logic        we      [2];
   logic [7:0]  addr    [2];
   logic [21:0] wdata   [2];
   logic [21:0] rdata   [2];
   logic        ack     [2];
   logic [21:0] dcw_o   [2];
   logic [21:0] dcw_i   [2];
   logic        dsec    [2];
   logic        dded    [2];
   logic [7:0]  secc    [2];
   logic [7:0]  dedc    [2];
   logic        flag    [2];
   logic [7:0]  daddr   [2];

   logic [21:0] mem [2][8];
   int          dly  [2];
   int          bcnt [2];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          u;
      logic [7:0]  a;
      logic [21:0] d;
   } wr_t;

   typedef struct {
      int         u;
      logic [7:0] s;
      logic [7:0] dd;
      logic       f;
      logic [7:0] a;
      int         cyc;
   } done_t;

   wr_t   exp_wr[$];
   done_t exp_done[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [21:0] clean_w(input int u, input int i);
      return 22'h03C00 + 22'(u * 64 + i * 7);
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_unit
      localparam int unsigned D = (k == 0) ? 4 : 6;
      localparam int unsigned C = (k == 0) ? 8 : 2;
      logic [C-1:0] sc;
      logic [C-1:0] dc;
      int           wcnt;
      logic         p_req;
      logic         p_ack;
      logic         p_we;
      logic [7:0]   p_addr;
      logic [21:0]  p_wd;

      ecc_scrub_ctrl #(
         .ADDR_W (8),
         .DEPTH  (D),
         .DATA_W (16),
         .CHK_W  (6),
         .CNT_W  (C)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .start_i     (start[k]),
         .busy_o      (busy[k]),
         .done_o      (done[k]),
         .mem_req_o   (req[k]),
         .mem_we_o    (we[k]),
         .mem_addr_o  (addr[k]),
         .mem_wdata_o (wdata[k]),
         .mem_rdata_i (rdata[k]),
         .mem_ack_i   (ack[k]),
         .dec_cw_o    (dcw_o[k]),
         .dec_cw_i    (dcw_i[k]),
         .dec_sec_i   (dsec[k]),
         .dec_ded_i   (dded[k]),
         .sec_cnt_o   (sc),
         .ded_cnt_o   (dc),
         .ded_flag_o  (flag[k]),
         .ded_addr_o  (daddr[k])
      );

      assign secc[k]  = 8'(sc);
      assign dedc[k]  = 8'(dc);
      assign dsec[k]  = dcw_o[k][21];
      assign dded[k]  = dcw_o[k][20];
      assign dcw_i[k] = {1'b0, dcw_o[k][20:0]};

      // Memory model: ack after dly wait cycles, one cycle wide
      always @(negedge clk) begin
         if (rst || !req[k]) begin
            ack[k] = 1'b0;
            wcnt   = 0;
         end else if (ack[k]) begin
            ack[k] = 1'b0;
            wcnt   = 0;
         end else if (wcnt >= dly[k]) begin
            ack[k] = 1'b1;
            if (we[k]) mem[k][addr[k][2:0]] = wdata[k];
            else       rdata[k] = mem[k][addr[k][2:0]];
         end else begin
            wcnt++;
         end
      end

      always @(negedge clk) begin
         if (busy[k]) bcnt[k]++;
      end

      // Monitor: scoreboard pops plus handshake stability
      always @(negedge clk) begin
         #1;
         if (req[k] && ack[k] && we[k]) begin
            if (exp_wr.size() == 0) begin
               chk("unexpected_write_addr", {56'd0, addr[k]}, 64'hFFFF);
            end else begin
               wr_t e;
               e = exp_wr.pop_front();
               chk("wr_unit", k, e.u);
               chk("wr_addr", addr[k], e.a);
               chk("wr_data", wdata[k], e.d);
            end
         end
         if (done[k]) begin
            if (exp_done.size() == 0) begin
               chk("unexpected_done", k, 64'hFFFF);
            end else begin
               done_t e;
               e = exp_done.pop_front();
               chk("done_unit", k, e.u);
               chk("sec_cnt", secc[k], e.s);
               chk("ded_cnt", dedc[k], e.dd);
               chk("ded_flag", flag[k], e.f);
               chk("ded_addr", daddr[k], e.a);
               chk("busy_cycles", bcnt[k], e.cyc);
            end
         end
         if (!rst) begin
            if (p_ack) begin
               chk("req_gap", req[k], 0);
            end else if (p_req && req[k]) begin
               chk("stable_addr", addr[k], p_addr);
               chk("stable_we", we[k], p_we);
               if (we[k]) chk("stable_wdata", wdata[k], p_wd);
            end
            p_req  = req[k];
            p_ack  = ack[k];
            p_we   = we[k];
            p_addr = addr[k];
            p_wd   = wdata[k];
         end else begin
            p_req = 1'b0;
            p_ack = 1'b0;
         end
      end
   end

   task automatic init_mem(input int u);
      for (int i = 0; i < 8; i++) mem[u][i] = clean_w(u, i);
   endtask

   task automatic push_done(input int u, input int s, input int d, input int f,
                            input int a, input int cyc);
      done_t e;
      e.u = u; e.s = 8'(s); e.dd = 8'(d); e.f = f[0]; e.a = 8'(a); e.cyc = cyc;
      exp_done.push_back(e);
   endtask

   task automatic push_wr(input int u, input int a, input logic [21:0] d);
      wr_t e;
      e.u = u; e.a = 8'(a); e.d = d;
      exp_wr.push_back(e);
   endtask

   task automatic check_zero(input int u);
      chk("rst_busy",  busy[u],  0);
      chk("rst_done",  done[u],  0);
      chk("rst_req",   req[u],   0);
      chk("rst_we",    we[u],    0);
      chk("rst_addr",  addr[u],  0);
      chk("rst_wdata", wdata[u], 0);
      chk("rst_deccw", dcw_o[u], 0);
      chk("rst_secc",  secc[u],  0);
      chk("rst_dedc",  dedc[u],  0);
      chk("rst_flag",  flag[u],  0);
      chk("rst_daddr", daddr[u], 0);
   endtask

   // Issue start, optionally poke start mid-pass and on the done cycle
   task automatic run_pass(input int u, input bit extra);
      int n;
      bcnt[u] = 0;
      @(negedge clk); start[u] = 1'b1;
      @(negedge clk); start[u] = 1'b0;
      if (extra) begin
         repeat (4) @(negedge clk);
         start[u] = 1'b1;
         @(negedge clk); start[u] = 1'b0;
      end
      n = 0;
      while (!done[u] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", done[u], 1);
      if (extra) start[u] = 1'b1;
      @(negedge clk); start[u] = 1'b0;
      #2 chk("idle_busy", busy[u], 0);
      if (extra) begin
         @(negedge clk);
         #2 chk("no_restart", busy[u], 0);
      end
      chk("wr_q_empty",   exp_wr.size(),   0);
      chk("done_q_empty", exp_done.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout actual=%0t required=done", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b0;
      for (int u = 0; u < 2; u++) begin
         start[u] = 1'b0;
         dly[u]   = 0;
         bcnt[u]  = 0;
         init_mem(u);
      end
      #3 rst = 1'b1;
      #10;
      check_zero(0);
      check_zero(1);
      @(negedge clk); rst = 1'b0;

      // Clean pass, 12 busy cycles, start pokes ignored
      push_done(0, 0, 0, 0, 0, 12);
      run_pass(0, 1'b1);

      // Single corrected word at address 2
      init_mem(0);
      mem[0][2] = clean_w(0, 2) | 22'h200000;
      push_wr(0, 2, clean_w(0, 2));
      push_done(0, 1, 0, 0, 0, 13);
      run_pass(0, 1'b0);
      chk("mem2_fixed", mem[0][2], clean_w(0, 2));

      // Uncorrectable words at addresses 1 and 3
      init_mem(0);
      mem[0][1] = clean_w(0, 1) | 22'h100000;
      mem[0][3] = clean_w(0, 3) | 22'h100000;
      push_done(0, 0, 2, 1, 1, 12);
      run_pass(0, 1'b0);

      // Three wait cycles on every request
      init_mem(0);
      dly[0] = 3;
      push_done(0, 0, 0, 0, 0, 24);
      run_pass(0, 1'b0);
      dly[0] = 0;

      // Narrow counter saturates, every word written back
      init_mem(1);
      for (int i = 0; i < 6; i++) begin
         mem[1][i] = clean_w(1, i) | 22'h200000;
         push_wr(1, i, clean_w(1, i));
      end
      push_done(1, 3, 0, 0, 0, 24);
      run_pass(1, 1'b0);

      // Reset while a writeback waits for ack
      init_mem(0);
      mem[0][0] = clean_w(0, 0) | 22'h200000;
      dly[0] = 5;
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      n = 0;
      while (!(req[0] && we[0]) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wb_reached", req[0] && we[0], 1);
      #2 rst = 1'b1;
      #1 check_zero(0);
      @(negedge clk); rst = 1'b0;
      dly[0] = 0;
      chk("no_partial_wr", mem[0][0], clean_w(0, 0) | 22'h200000);
      push_wr(0, 0, clean_w(0, 0));
      push_done(0, 1, 0, 0, 0, 13);
      run_pass(0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
